// File: rtl/booth_if.sv
// Handshake bundle for booth_seq_multiplier: request side (start/operands) and
// result side (busy/done/product/overflow) plus the FSM state for checkers.
interface booth_if #(
  parameter int WIDTH = 32
);
  // Handshake: the master raises start with operands valid; the slave accepts on
  // any rising edge where start=1 and busy=0. busy stays high until the result
  // edge, done pulses for one cycle with product/overflow valid, and those
  // outputs hold until the completion of the next accepted operation.
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     product_lo;
  logic                 overflow;
  logic                 state_dbg;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, product, product_lo, overflow, state_dbg
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, product, product_lo, overflow, state_dbg
  );
endinterface

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: WIDTH+1 steps per operation on
// (WIDTH+1)-bit extended operands, giving signed and unsigned products.
module booth_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  booth_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH+1:0]   h_q, h_d;
  logic [WIDTH:0]     l_q, l_d;
  logic               q_q, q_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH+1:0]   m_ext;
  logic [WIDTH+1:0]   h_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic               last_step;
  logic               ovf_s;
  logic               ovf_u;

  always_comb begin
    m_ext = {m_q[WIDTH], m_q};
    unique case ({l_q[0], q_q})
      2'b01:   h_sum = h_q + m_ext;
      2'b10:   h_sum = h_q - m_ext;
      default: h_sum = h_q;
    endcase
    last_step = (state_q == S_RUN) && (cnt_q == CW'(WIDTH));
    // Low 2*WIDTH bits of {H,L} after this step's arithmetic shift.
    prod_next = {h_sum[WIDTH-1:0], l_q[WIDTH:1]};
    ovf_s = (|prod_next[2*WIDTH-1:WIDTH-1]) && !(&prod_next[2*WIDTH-1:WIDTH-1]);
    ovf_u = |prod_next[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    m_d     = m_q;
    h_d     = h_q;
    l_d     = l_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    prod_d  = prod_q;
    if (state_q == S_IDLE) begin
      if (bus.start) begin
        state_d = S_RUN;
        sgn_d   = bus.is_signed;
        m_d     = {bus.is_signed & bus.a[WIDTH-1], bus.a};
        l_d     = {bus.is_signed & bus.b[WIDTH-1], bus.b};
        h_d     = '0;
        q_d     = 1'b0;
        cnt_d   = '0;
      end
    end else begin
      h_d   = {h_sum[WIDTH+1], h_sum[WIDTH+1:1]};
      l_d   = {h_sum[0], l_q[WIDTH:1]};
      q_d   = l_q[0];
      cnt_d = cnt_q + 1'b1;
      if (last_step) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        prod_d  = prod_next;
        ovf_d   = sgn_q ? ovf_s : ovf_u;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      m_q     <= '0;
      h_q     <= '0;
      l_q     <= '0;
      q_q     <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      m_q     <= m_d;
      h_q     <= h_d;
      l_q     <= l_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy       = (state_q == S_RUN);
  assign bus.done       = done_q;
  assign bus.product    = prod_q;
  assign bus.product_lo = prod_q[WIDTH-1:0];
  assign bus.overflow   = ovf_q;
  assign bus.state_dbg  = state_q;
endmodule
